// File: rtl/mem_pkg.sv
// Shared op codes, exception codes and FSM state type for the memory-access stage.
package mem_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  localparam logic [1:0] EXC_ADEL    = 2'd0;
  localparam logic [1:0] EXC_ADES    = 2'd1;
  localparam logic [1:0] EXC_BUSERR  = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Little-endian byte-lane formatting: store lane enables/replication, load
// extraction with sign/zero extension, and natural-alignment check.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword out of the read word
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Lane enables, replicated store data, alignment check and load extension
  always_comb begin
    o_sel        = 4'b0000;
    o_wdata      = i_store_data;
    o_load_data  = i_rdata;
    o_misaligned = 1'b0;
    case (i_op)
      OP_LB, OP_LBU, OP_SB: o_sel = 4'b0001 << i_addr_lo;
      OP_LH, OP_LHU, OP_SH: begin
        o_sel        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_misaligned = i_addr_lo[0];
      end
      OP_LW, OP_SW: begin
        o_sel        = 4'b1111;
        o_misaligned = |i_addr_lo;
      end
      default: o_sel = 4'b0000;
    endcase
    case (i_op)
      OP_SB:   o_wdata = {4{i_store_data[7:0]}};
      OP_SH:   o_wdata = {2{i_store_data[15:0]}};
      default: o_wdata = i_store_data;
    endcase
    case (i_op)
      OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load_data = {24'd0, w_byte};
      OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load_data = {16'd0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Registered MEM stage with req/ack data-bus handshake and merged MEM/WB outputs.
//
//   state     | meaning
//   ST_IDLE   | accepting from EX/MEM; non-memory and misaligned ops retire in one cycle
//   ST_ACCESS | bus request outstanding; upstream held until ack/err/timeout
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              valid_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              exc_o,
  output logic [1:0]        exc_code_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_ack_i,
  input  logic              bus_err_i
);

  // Counter holds 0..TIMEOUT_CYC-1; a zero TIMEOUT_CYC disables the timeout entirely.
  localparam int                CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int                LAST_I   = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LAST_I);
  localparam bit                TO_EN    = (TIMEOUT_CYC > 0);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_drop;
  logic [3:0]          r_acc_op;
  logic [ADDR_W-1:0]   r_acc_addr;
  logic [3:0]          r_acc_sel;
  logic [31:0]         r_acc_wdata;
  logic [REG_AW-1:0]   r_acc_wd;
  logic                r_acc_wreg;
  logic                r_valid;
  logic                r_exc;
  logic [1:0]          r_exc_code;
  logic [ADDR_W-1:0]   r_badvaddr;
  logic [REG_AW-1:0]   r_wd;
  logic                r_wreg;
  logic [31:0]         r_wdata;

  logic                w_in_access;
  logic [3:0]          w_fmt_op;
  logic [1:0]          w_fmt_addr_lo;
  logic [3:0]          w_sel;
  logic [31:0]         w_fmt_wdata;
  logic [31:0]         w_load_data;
  logic                w_misal;
  logic                w_is_mem;
  logic                w_start;
  logic                w_timeout;
  logic                w_term;

  assign w_in_access = (r_state == ST_ACCESS);

  // The formatter sees the incoming op in IDLE (sel/data/alignment) and the
  // latched op in ACCESS (load extraction from the returning read data).
  assign w_fmt_op      = w_in_access ? r_acc_op : op_i;
  assign w_fmt_addr_lo = w_in_access ? r_acc_addr[1:0] : addr_i[1:0];

  mem_lane_fmt u_lane_fmt (
    .i_op         (w_fmt_op),
    .i_addr_lo    (w_fmt_addr_lo),
    .i_store_data (store_data_i),
    .i_rdata      (bus_rdata_i),
    .o_sel        (w_sel),
    .o_wdata      (w_fmt_wdata),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misal)
  );

  assign w_is_mem  = op_is_load(op_i) || op_is_store(op_i);
  assign w_start   = !w_in_access && valid_i && !flush_i && w_is_mem && !w_misal;
  assign w_timeout = TO_EN && (r_cnt == CNT_LAST);
  assign w_term    = w_in_access && (bus_ack_i || bus_err_i || w_timeout);

  // Stall drops in the terminating cycle so the upstream stage advances on the retiring edge
  assign stall_req_o = w_start || (w_in_access && !w_term);

  assign bus_req_o   = w_in_access;
  assign bus_we_o    = w_in_access && op_is_store(r_acc_op);
  assign bus_addr_o  = w_in_access ? {r_acc_addr[ADDR_W-1:2], 2'b00} : '0;
  assign bus_sel_o   = w_in_access ? r_acc_sel : 4'b0000;
  assign bus_wdata_o = w_in_access ? r_acc_wdata : 32'd0;

  assign valid_o    = r_valid;
  assign exc_o      = r_exc;
  assign exc_code_o = r_exc_code;
  assign badvaddr_o = r_badvaddr;
  assign wd_o       = r_wd;
  assign wreg_o     = r_wreg;
  assign wdata_o    = r_wdata;

  // Sequencer: accept from EX/MEM, run the bus access, retire into the writeback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
      r_acc_op    <= OP_NONE;
      r_acc_addr  <= '0;
      r_acc_sel   <= 4'b0000;
      r_acc_wdata <= 32'd0;
      r_acc_wd    <= '0;
      r_acc_wreg  <= 1'b0;
      r_valid     <= 1'b0;
      r_exc       <= 1'b0;
      r_exc_code  <= 2'd0;
      r_badvaddr  <= '0;
      r_wd        <= '0;
      r_wreg      <= 1'b0;
      r_wdata     <= 32'd0;
    end else begin
      r_valid <= 1'b0;
      r_exc   <= 1'b0;
      r_wreg  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid_i && !flush_i) begin
            if (!w_is_mem) begin
              r_valid <= 1'b1;
              r_wd    <= wd_i;
              r_wreg  <= wreg_i;
              r_wdata <= wdata_i;
            end else if (w_misal) begin
              r_valid    <= 1'b1;
              r_exc      <= 1'b1;
              r_exc_code <= op_is_store(op_i) ? EXC_ADES : EXC_ADEL;
              r_badvaddr <= addr_i;
            end else begin
              r_state     <= ST_ACCESS;
              r_cnt       <= '0;
              r_drop      <= 1'b0;
              r_acc_op    <= op_i;
              r_acc_addr  <= addr_i;
              r_acc_sel   <= w_sel;
              r_acc_wdata <= w_fmt_wdata;
              r_acc_wd    <= wd_i;
              r_acc_wreg  <= wreg_i;
            end
          end
        end
        ST_ACCESS: begin
          if (w_term) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
            // A flush seen at any point of the access, including this cycle, discards the result
            if (!(r_drop || flush_i)) begin
              r_valid <= 1'b1;
              if (bus_err_i) begin
                r_exc      <= 1'b1;
                r_exc_code <= EXC_BUSERR;
                r_badvaddr <= r_acc_addr;
              end else if (bus_ack_i) begin
                r_wd <= r_acc_wd;
                if (op_is_load(r_acc_op)) begin
                  r_wreg  <= r_acc_wreg;
                  r_wdata <= w_load_data;
                end
              end else begin
                r_exc      <= 1'b1;
                r_exc_code <= EXC_TIMEOUT;
                r_badvaddr <= r_acc_addr;
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (flush_i) r_drop <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed plan cases plus randomized ops against an arithmetic model.
module tb_mem_stage_hs;
  import mem_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        flush_i;
  logic        stall_req_o;
  logic        valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        exc_o;
  logic [1:0]  exc_code_o;
  logic [31:0] badvaddr_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_i;

  int total = 0;
  int bad   = 0;

  // observations from the last run_op
  int          o_lat, o_stall, o_req;
  bit          o_valid, o_exc, o_unstable;
  logic [1:0]  o_code;
  logic [31:0] o_wdata, o_badv, o_bwdata, o_baddr;
  logic [4:0]  o_wd;
  logic        o_wreg, o_we;
  logic [3:0]  o_sel;

  always #5 clk = ~clk;

  mem_stage_hs #(.ADDR_W(32), .REG_AW(5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .flush_i(flush_i), .stall_req_o(stall_req_o), .valid_o(valid_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .exc_o(exc_o), .exc_code_o(exc_code_o),
    .badvaddr_o(badvaddr_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
  );

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [3:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit m_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [3:0] exp_sel(input logic [3:0] op, input logic [31:0] a);
    int off = int'(a % 4);
    int sz  = op_size(op);
    int lanes = (1 << sz) - 1;
    return 4'(lanes << (off - off % sz));
  endfunction

  function automatic logic [31:0] exp_bwdata(input logic [3:0] op, input logic [31:0] sd);
    if (op == OP_SB) return (sd % 256) * 32'h01010101;
    if (op == OP_SH) return (sd % 65536) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    int off = int'(a % 4);
    logic [31:0] v;
    if (op == OP_LW) return rd;
    if (op_size(op) == 1) begin
      v = (rd >> (8 * off)) % 256;
      if (op == OP_LB && v >= 128) v = v + 32'hFFFFFF00;
    end else begin
      v = (rd >> (8 * (off - off % 2))) % 65536;
      if (op == OP_LH && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  // ---------------- stimulus driver (no checking) ----------------
  // ack_k/err_k/flush_k: ACCESS-cycle index at which to assert, -1 = never.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] wdat, input logic [4:0] wd, input logic wreg,
                        input int ack_k, input int err_k, input int flush_k,
                        input logic [31:0] rdata);
    bit first = 1'b1;
    o_lat = -1; o_stall = 0; o_req = 0; o_valid = 0; o_exc = 0; o_unstable = 0;
    o_code = 0; o_wdata = 0; o_badv = 0; o_wd = 0; o_wreg = 0;
    o_sel = 0; o_we = 0; o_bwdata = 0; o_baddr = 0;
    valid_i = 1'b1; op_i = op; addr_i = addr; store_data_i = sdata;
    wdata_i = wdat; wd_i = wd; wreg_i = wreg; flush_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        valid_i = 1'b0;
        op_i    = 4'($urandom_range(0, 8));
        addr_i  = $urandom();
      end
      bus_ack_i   = (c >= 1) && (c - 1 == ack_k);
      bus_err_i   = (c >= 1) && (c - 1 == err_k);
      flush_i     = (c >= 1) && (c - 1 == flush_k);
      bus_rdata_i = ((c >= 1) && (c - 1 == ack_k)) ? rdata : $urandom();
      @(negedge clk);
      if (valid_o) begin
        o_valid = 1'b1; o_lat = c; o_exc = exc_o; o_code = exc_code_o;
        o_wdata = wdata_o; o_wd = wd_o; o_wreg = wreg_o; o_badv = badvaddr_o;
        break;
      end
      if (c > 0 && !bus_req_o) break;
      if (stall_req_o) o_stall++;
      if (bus_req_o) begin
        if (first) begin
          o_sel = bus_sel_o; o_we = bus_we_o; o_bwdata = bus_wdata_o; o_baddr = bus_addr_o;
          first = 1'b0;
        end else if (o_sel !== bus_sel_o || o_we !== bus_we_o ||
                     o_bwdata !== bus_wdata_o || o_baddr !== bus_addr_o) begin
          o_unstable = 1'b1;
        end
        o_req++;
      end
      @(posedge clk); #1;
    end
    bus_ack_i = 1'b0; bus_err_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; valid_i = 0; op_i = 0; addr_i = 0; store_data_i = 0; wd_i = 0; wreg_i = 0;
    wdata_i = 0; flush_i = 0; bus_rdata_i = 0; bus_ack_i = 0; bus_err_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({valid_o, exc_o, exc_code_o, wreg_o, wd_o, wdata_o, badvaddr_o, stall_req_o} !== '0) begin
      bad++; $display("FAIL reset_wb_outputs got valid=%b exc=%b code=%0d wreg=%b wd=%0d wdata=%h badv=%h stall=%b want all 0",
                      valid_o, exc_o, exc_code_o, wreg_o, wd_o, wdata_o, badvaddr_o, stall_req_o);
    end
    total++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== '0) begin
      bad++; $display("FAIL reset_bus_outputs got req=%b we=%b addr=%h sel=%b wdata=%h want all 0",
                      bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_nonmem;
    logic [31:0] wd32;
    logic [4:0]  wd;
    logic        wr;
    run_op(OP_NONE, 32'h0, 32'h0, 32'h12345678, 5'd3, 1'b1, -1, -1, -1, 32'h0);
    total++; if (o_lat !== 1) begin bad++; $display("FAIL nonmem_latency got=%0d want=1", o_lat); end
    total++; if (o_wdata !== 32'h12345678) begin bad++; $display("FAIL nonmem_wdata got=%h want=12345678", o_wdata); end
    total++; if (o_wd !== 5'd3 || o_wreg !== 1'b1) begin bad++; $display("FAIL nonmem_wd got wd=%0d wreg=%b want wd=3 wreg=1", o_wd, o_wreg); end
    total++; if (o_stall !== 0) begin bad++; $display("FAIL nonmem_stall got=%0d want=0", o_stall); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL nonmem_pulse got valid_o=%b want=0", valid_o); end
    for (int i = 0; i < 4; i++) begin
      wd32 = $urandom(); wd = 5'($urandom()); wr = 1'($urandom());
      run_op(OP_NONE, $urandom(), $urandom(), wd32, wd, wr, -1, -1, -1, 32'h0);
      total++;
      if (o_lat !== 1 || o_exc !== 1'b0 || o_wdata !== wd32 || o_wd !== wd || o_wreg !== wr) begin
        bad++; $display("FAIL nonmem_rand got lat=%0d exc=%b wdata=%h wd=%0d wreg=%b want lat=1 exc=0 wdata=%h wd=%0d wreg=%b",
                        o_lat, o_exc, o_wdata, o_wd, o_wreg, wd32, wd, wr);
      end
    end
  endtask

  task automatic test_lb;
    run_op(OP_LB, 32'h1003, 32'h0, 32'h0, 5'd9, 1'b1, 0, -1, -1, 32'h80FFFFFF);
    total++; if (o_sel !== 4'b1000) begin bad++; $display("FAIL lb_sel got=%b want=1000", o_sel); end
    total++; if (o_baddr !== 32'h1000 || o_we !== 1'b0) begin bad++; $display("FAIL lb_bus got addr=%h we=%b want addr=00001000 we=0", o_baddr, o_we); end
    total++; if (o_wdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_wdata got=%h want=ffffff80", o_wdata); end
    total++; if (o_stall !== 1 || o_lat !== 2) begin bad++; $display("FAIL lb_timing got stall=%0d lat=%0d want stall=1 lat=2", o_stall, o_lat); end
    total++; if (o_wreg !== 1'b1 || o_wd !== 5'd9) begin bad++; $display("FAIL lb_wreg got wreg=%b wd=%0d want wreg=1 wd=9", o_wreg, o_wd); end
  endtask

  task automatic test_sh;
    run_op(OP_SH, 32'h2002, 32'hABCD1234, 32'h0, 5'd4, 1'b1, 3, -1, -1, 32'h0);
    total++; if (o_sel !== 4'b1100 || o_we !== 1'b1) begin bad++; $display("FAIL sh_sel got sel=%b we=%b want sel=1100 we=1", o_sel, o_we); end
    total++; if (o_bwdata !== 32'h12341234) begin bad++; $display("FAIL sh_bus_wdata got=%h want=12341234", o_bwdata); end
    total++; if (o_stall !== 4 || o_req !== 4) begin bad++; $display("FAIL sh_stall got stall=%0d req=%0d want stall=4 req=4", o_stall, o_req); end
    total++; if (o_unstable !== 1'b0) begin bad++; $display("FAIL sh_bus_stable got unstable=%b want=0", o_unstable); end
    total++; if (o_valid !== 1'b1 || o_wreg !== 1'b0 || o_exc !== 1'b0) begin bad++; $display("FAIL sh_retire got valid=%b wreg=%b exc=%b want 1 0 0", o_valid, o_wreg, o_exc); end
  endtask

  task automatic test_misaligned;
    logic [3:0]  op;
    logic [31:0] a;
    logic [3:0]  ops [4] = '{OP_LH, OP_LHU, OP_SH, OP_LW};
    run_op(OP_LW, 32'h1001, 32'h0, 32'h0, 5'd1, 1'b1, 0, -1, -1, 32'h0);
    total++; if (o_req !== 0 || o_stall !== 0) begin bad++; $display("FAIL adel_no_req got req=%0d stall=%0d want 0 0", o_req, o_stall); end
    total++; if (o_valid !== 1'b1 || o_exc !== 1'b1 || o_code !== EXC_ADEL || o_badv !== 32'h1001 || o_wreg !== 1'b0) begin
      bad++; $display("FAIL adel_lw got valid=%b exc=%b code=%0d badv=%h wreg=%b want 1 1 0 00001001 0", o_valid, o_exc, o_code, o_badv, o_wreg); end
    run_op(OP_SW, 32'h1002, 32'h0, 32'h0, 5'd1, 1'b1, 0, -1, -1, 32'h0);
    total++; if (o_exc !== 1'b1 || o_code !== EXC_ADES || o_badv !== 32'h1002 || o_lat !== 1) begin
      bad++; $display("FAIL ades_sw got exc=%b code=%0d badv=%h lat=%0d want 1 1 00001002 1", o_exc, o_code, o_badv, o_lat); end
    for (int i = 0; i < 6; i++) begin
      op = (i % 5 == 4) ? OP_SW : ops[i % 4];
      a  = $urandom();
      if (op_size(op) == 2) a = a | 32'h1;
      else if (a % 4 == 0) a = a + 32'($urandom_range(1, 3));
      run_op(op, a, $urandom(), 32'h0, 5'd2, 1'b1, 0, -1, -1, 32'h0);
      total++;
      if (o_req !== 0 || o_exc !== 1'b1 || o_code !== (m_is_store(op) ? 2'd1 : 2'd0) || o_badv !== a || o_wreg !== 1'b0) begin
        bad++; $display("FAIL misal_rand op=%0d addr=%h got req=%0d exc=%b code=%0d badv=%h wreg=%b", op, a, o_req, o_exc, o_code, o_badv, o_wreg);
      end
    end
  endtask

  task automatic test_random_ops;
    logic [3:0]  op;
    logic [31:0] a, sd, rd;
    logic [4:0]  wd;
    logic        wr;
    int          k;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(1, 8));
      a  = $urandom(); a = a - (a % 32'(op_size(op)));
      sd = $urandom(); rd = $urandom(); wd = 5'($urandom()); wr = 1'($urandom());
      k  = $urandom_range(0, 4);
      run_op(op, a, sd, 32'h0, wd, wr, k, -1, -1, rd);
      total++;
      if (o_lat !== k + 2 || o_stall !== k + 1 || o_req !== k + 1 || o_unstable !== 1'b0) begin
        bad++; $display("FAIL rand_timing op=%0d k=%0d got lat=%0d stall=%0d req=%0d unstable=%b", op, k, o_lat, o_stall, o_req, o_unstable);
      end
      total++;
      if (o_sel !== exp_sel(op, a) || o_we !== m_is_store(op) || o_baddr !== (a & 32'hFFFFFFFC)) begin
        bad++; $display("FAIL rand_bus op=%0d addr=%h got sel=%b we=%b baddr=%h want sel=%b we=%b", op, a, o_sel, o_we, o_baddr, exp_sel(op, a), m_is_store(op));
      end
      total++;
      if (m_is_store(op)) begin
        if (o_bwdata !== exp_bwdata(op, sd) || o_wreg !== 1'b0 || o_exc !== 1'b0) begin
          bad++; $display("FAIL rand_store op=%0d got bwdata=%h wreg=%b exc=%b want bwdata=%h wreg=0 exc=0", op, o_bwdata, o_wreg, o_exc, exp_bwdata(op, sd));
        end
      end else begin
        if (o_wdata !== exp_load(op, a, rd) || o_wreg !== wr || o_wd !== wd || o_exc !== 1'b0) begin
          bad++; $display("FAIL rand_load op=%0d addr=%h rdata=%h got wdata=%h wreg=%b wd=%0d want wdata=%h wreg=%b wd=%0d",
                          op, a, rd, o_wdata, o_wreg, o_wd, exp_load(op, a, rd), wr, wd);
        end
      end
    end
  endtask

  task automatic test_timeout_and_err;
    run_op(OP_LW, 32'h4000, 32'h0, 32'h0, 5'd5, 1'b1, -1, -1, -1, 32'h0);
    total++; if (o_valid !== 1'b1 || o_exc !== 1'b1 || o_code !== EXC_TIMEOUT || o_badv !== 32'h4000) begin
      bad++; $display("FAIL timeout_exc got valid=%b exc=%b code=%0d badv=%h want 1 1 3 00004000", o_valid, o_exc, o_code, o_badv); end
    total++; if (o_req !== TO || o_lat !== TO + 1 || o_stall !== TO) begin
      bad++; $display("FAIL timeout_cycles got req=%0d lat=%0d stall=%0d want %0d %0d %0d", o_req, o_lat, o_stall, TO, TO + 1, TO); end
    total++; if (o_wreg !== 1'b0) begin bad++; $display("FAIL timeout_wreg got=%b want=0", o_wreg); end
    run_op(OP_LHU, 32'h5006, 32'h0, 32'h0, 5'd6, 1'b1, 1, 1, -1, 32'h55AA55AA);
    total++; if (o_exc !== 1'b1 || o_code !== EXC_BUSERR || o_badv !== 32'h5006 || o_wreg !== 1'b0 || o_lat !== 3) begin
      bad++; $display("FAIL ack_err_same got exc=%b code=%0d badv=%h wreg=%b lat=%0d want 1 2 00005006 0 3", o_exc, o_code, o_badv, o_wreg, o_lat); end
    run_op(OP_SB, 32'h6001, 32'h0, 32'h0, 5'd6, 1'b1, -1, 2, -1, 32'h0);
    total++; if (o_exc !== 1'b1 || o_code !== EXC_BUSERR || o_lat !== 4) begin
      bad++; $display("FAIL err_only got exc=%b code=%0d lat=%0d want 1 2 4", o_exc, o_code, o_lat); end
  endtask

  task automatic test_flush;
    run_op(OP_LW, 32'h7000, 32'h0, 32'h0, 5'd8, 1'b1, 3, -1, 1, 32'hDEADBEEF);
    total++; if (o_valid !== 1'b0 || o_req !== 4) begin bad++; $display("FAIL flush_access got valid=%b req=%0d want valid=0 req=4", o_valid, o_req); end
    run_op(OP_LW, 32'h7004, 32'h0, 32'h0, 5'd8, 1'b1, 0, -1, -1, 32'hCAFEF00D);
    total++; if (o_valid !== 1'b1 || o_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL flush_recover got valid=%b wdata=%h want 1 cafef00d", o_valid, o_wdata); end
    valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h7008; wd_i = 5'd1; wreg_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    total++; if (stall_req_o !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b want=0", stall_req_o); end
    @(posedge clk); #1; valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    total++; if (bus_req_o !== 1'b0 || valid_o !== 1'b0) begin bad++; $display("FAIL flush_idle got req=%b valid=%b want 0 0", bus_req_o, valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid;
    valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h3000; wd_i = 5'd7; wreg_i = 1'b1;
    @(posedge clk); #1; valid_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got req=%b want=1", bus_req_o); end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL rst_mid_req got=%b want=0", bus_req_o); end
    total++;
    if ({valid_o, exc_o, exc_code_o, wreg_o, wd_o, wdata_o, badvaddr_o, stall_req_o,
         bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs got wdata=%h wd=%0d badv=%h code=%0d sel=%b addr=%h want all 0",
                      wdata_o, wd_o, badvaddr_o, exc_code_o, bus_sel_o, bus_addr_o);
    end
    bus_ack_i = 1'b1; bus_err_i = 1'b1;
    @(posedge clk); #1; bus_ack_i = 1'b0; bus_err_i = 1'b0;
    @(negedge clk);
    total++; if (valid_o !== 1'b0 || exc_o !== 1'b0 || bus_req_o !== 1'b0) begin
      bad++; $display("FAIL stray_ack got valid=%b exc=%b req=%b want 0 0 0", valid_o, exc_o, bus_req_o); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_lb();
    test_sh();
    test_misaligned();
    test_random_ops();
    test_timeout_and_err();
    test_flush();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
